// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Tracks the instruction class, bus wait time, retired count and sticky trap state.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [6:0]       i_opcode,
  input  logic             i_insn_vld,
  input  logic             i_rd_wren,
  input  logic             i_imem_ack,
  input  logic             i_dmem_ack,
  output logic             o_imem_req,
  output logic             o_ir_en,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_rf_we,
  output logic             o_pc_en,
  output logic [2:0]       o_state,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_OTHER  = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } class_t;

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t             state;
  class_t             cls;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retire_cnt;
  logic               trap;
  logic [1:0]         trap_cause;
  logic               timeout_hit;

  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LAST);

  // Outputs come straight from the state register and live acks so a
  // zero-wait memory completes in the same cycle; reset forces them all low.
  always_comb begin
    o_imem_req   = 1'b0;
    o_ir_en      = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_rf_we      = 1'b0;
    o_pc_en      = 1'b0;
    o_state      = 3'd0;
    o_trap       = 1'b0;
    o_trap_cause = 2'b00;
    o_retire_cnt = '0;
    if (!i_reset) begin
      o_state      = state;
      o_trap       = trap;
      o_trap_cause = trap_cause;
      o_retire_cnt = retire_cnt;
      case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_en    = i_imem_ack;
        end
        S_EXEC:  o_pc_en = (cls == C_BRANCH);
        S_MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = (cls == C_STORE);
          o_pc_en    = i_dmem_ack && (cls == C_STORE);
        end
        S_WB: begin
          o_rf_we = i_rd_wren;
          o_pc_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_FETCH;
      cls        <= C_OTHER;
      wait_cnt   <= '0;
      retire_cnt <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      // Every retire path raises o_pc_en exactly once, so it doubles as the count strobe.
      if (o_pc_en) retire_cnt <= retire_cnt + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (i_imem_ack) begin
            state <= S_DECODE;
          end else if (timeout_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (!i_insn_vld) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end else begin
            state <= S_EXEC;
            case (i_opcode)
              7'b0000011: cls <= C_LOAD;
              7'b0100011: cls <= C_STORE;
              7'b1100011: cls <= C_BRANCH;
              default:    cls <= C_OTHER;
            endcase
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (cls)
            C_LOAD, C_STORE: state <= S_MEM;
            C_BRANCH:        state <= S_FETCH;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (i_dmem_ack) begin
            wait_cnt <= '0;
            state    <= (cls == C_STORE) ? S_FETCH : S_WB;
          end else if (timeout_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a per-cycle vector table for the main instruction
// flows plus hand-written sequences for timeout, reset-abandon and counter wrap.
module tb_mc_ctrl_fsm;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Enable bit groups, ordered {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, trap}
  localparam logic [6:0] EN_NONE    = 7'b0000000;
  localparam logic [6:0] EN_FETCH   = 7'b1000000;
  localparam logic [6:0] EN_FETCHAK = 7'b1100000;
  localparam logic [6:0] EN_LOAD    = 7'b0010000;
  localparam logic [6:0] EN_STOREAK = 7'b0011010;
  localparam logic [6:0] EN_WB      = 7'b0000110;
  localparam logic [6:0] EN_BRANCH  = 7'b0000010;
  localparam logic [6:0] EN_TRAP    = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = OP_ADDI;
  logic       insn_vld = 1'b1;
  logic       rd_wren = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, trap;
  logic [2:0] state;
  logic [1:0] trap_cause;
  logic [3:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.TIMEOUT_CYC(16), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_insn_vld(insn_vld),
    .i_rd_wren(rd_wren), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_imem_req(imem_req), .o_ir_en(ir_en), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_rf_we(rf_we), .o_pc_en(pc_en), .o_state(state), .o_trap(trap),
    .o_trap_cause(trap_cause), .o_retire_cnt(retire_cnt)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic       vld;
    logic       rdw;
    logic       iack;
    logic       dack;
    logic [15:0] want;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] e(logic [2:0] st, logic [6:0] en, logic [1:0] cause, logic [3:0] ret);
    return {st, en, cause, ret};
  endfunction

  function automatic vec_t mk(string n, logic rst, logic [6:0] op, logic vld, logic rdw,
                              logic iack, logic dack, logic [15:0] want);
    vec_t v;
    v.name = n; v.rst = rst; v.op = op; v.vld = vld; v.rdw = rdw;
    v.iack = iack; v.dack = dack; v.want = want;
    return v;
  endfunction

  function automatic logic [15:0] observed();
    return {state, imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, trap, trap_cause, retire_cnt};
  endfunction

  task automatic checkVal(string n, logic [15:0] act, logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", n, act, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    reset = v.rst; opcode = v.op; insn_vld = v.vld; rd_wren = v.rdw;
    imem_ack = v.iack; dmem_ack = v.dack;
    #1;
  endtask

  task automatic checkOutput(vec_t v);
    checkVal(v.name, observed(), v.want);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; rd_wren = 1'b0;
    insn_vld = 1'b1; opcode = OP_ADDI;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    bit done;

    // ADDI with imem ack held high
    tbl.push_back(mk("t1_reset",  1, OP_ADDI, 1, 1, 1, 0, e(3'd0, EN_NONE,    2'd0, 4'd0)));
    tbl.push_back(mk("t1_fetch",  0, OP_ADDI, 1, 1, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'd0)));
    tbl.push_back(mk("t1_decode", 0, OP_ADDI, 1, 1, 1, 0, e(3'd1, EN_NONE,    2'd0, 4'd0)));
    tbl.push_back(mk("t1_exec",   0, OP_ADDI, 1, 1, 1, 0, e(3'd2, EN_NONE,    2'd0, 4'd0)));
    tbl.push_back(mk("t1_wb",     0, OP_ADDI, 1, 1, 1, 0, e(3'd4, EN_WB,      2'd0, 4'd0)));
    // LW with data ack on the third MEM cycle
    tbl.push_back(mk("t2_fetch",  0, OP_LW, 1, 1, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'd1)));
    tbl.push_back(mk("t2_decode", 0, OP_LW, 1, 1, 1, 0, e(3'd1, EN_NONE,    2'd0, 4'd1)));
    tbl.push_back(mk("t2_exec",   0, OP_LW, 1, 1, 1, 0, e(3'd2, EN_NONE,    2'd0, 4'd1)));
    tbl.push_back(mk("t2_mem1",   0, OP_LW, 1, 1, 1, 0, e(3'd3, EN_LOAD,    2'd0, 4'd1)));
    tbl.push_back(mk("t2_mem2",   0, OP_LW, 1, 1, 1, 0, e(3'd3, EN_LOAD,    2'd0, 4'd1)));
    tbl.push_back(mk("t2_mem3",   0, OP_LW, 1, 1, 1, 1, e(3'd3, EN_LOAD,    2'd0, 4'd1)));
    tbl.push_back(mk("t2_wb",     0, OP_LW, 1, 1, 1, 0, e(3'd4, EN_WB,      2'd0, 4'd1)));
    // SW with data ack on the first MEM cycle; rd_wren high must not reach the regfile
    tbl.push_back(mk("t3_fetch",  0, OP_SW, 1, 1, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'd2)));
    tbl.push_back(mk("t3_decode", 0, OP_SW, 1, 1, 1, 0, e(3'd1, EN_NONE,    2'd0, 4'd2)));
    tbl.push_back(mk("t3_exec",   0, OP_SW, 1, 1, 1, 0, e(3'd2, EN_NONE,    2'd0, 4'd2)));
    tbl.push_back(mk("t3_mem",    0, OP_SW, 1, 1, 1, 1, e(3'd3, EN_STOREAK, 2'd0, 4'd2)));
    // BEQ retires in three cycles, then an illegal instruction traps
    tbl.push_back(mk("t4_fetch",  0, OP_BEQ, 1, 1, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'd3)));
    tbl.push_back(mk("t4_decode", 0, OP_BEQ, 1, 1, 1, 0, e(3'd1, EN_NONE,    2'd0, 4'd3)));
    tbl.push_back(mk("t4_exec",   0, OP_BEQ, 1, 1, 1, 0, e(3'd2, EN_BRANCH,  2'd0, 4'd3)));
    tbl.push_back(mk("t4_fetch2", 0, OP_ADDI, 0, 1, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'd4)));
    tbl.push_back(mk("t4_illegal",0, OP_ADDI, 0, 1, 1, 0, e(3'd1, EN_NONE,    2'd0, 4'd4)));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk($sformatf("t4_trap%0d", i), 0, OP_ADDI, 0, 1, 1, 1,
                       e(3'd5, EN_TRAP, 2'd1, 4'd4)));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Instruction memory never answers: expect exactly 16 FETCH cycles, then a bus-timeout trap
    resetDut();
    cycles = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (state == 3'd5) done = 1'b1;
      else begin
        if (state == 3'd0) cycles++;
        @(negedge clk);
        #1;
      end
    end
    checkVal("t5_trap_reached", 16'(done), 16'd1);
    checkVal("t5_fetch_cycles", 16'(cycles), 16'd16);
    checkVal("t5_trap_out", observed(), e(3'd5, EN_TRAP, 2'd2, 4'd0));

    // Ack arrives on the 16th wait cycle: it wins over the timeout
    resetDut();
    repeat (15) @(negedge clk);
    imem_ack = 1'b1;
    #1;
    checkVal("t5_ack16_fetch", observed(), e(3'd0, EN_FETCHAK, 2'd0, 4'd0));
    opcode = OP_LW;
    insn_vld = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    checkVal("t5_ack16_decode", observed(), e(3'd1, EN_NONE, 2'd0, 4'd0));

    // Reset during MEM of a load abandons it without retiring or writing
    @(negedge clk);
    #1;
    checkVal("t6_exec", observed(), e(3'd2, EN_NONE, 2'd0, 4'd0));
    @(negedge clk);
    #1;
    checkVal("t6_mem", observed(), e(3'd3, EN_LOAD, 2'd0, 4'd0));
    @(negedge clk);
    reset = 1'b1; rd_wren = 1'b1; dmem_ack = 1'b1; imem_ack = 1'b1;
    #1;
    checkVal("t6_in_reset", observed(), 16'h0000);
    @(negedge clk);
    reset = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0;
    #1;
    checkVal("t6_after_reset", observed(), e(3'd0, EN_FETCH, 2'd0, 4'd0));

    // Sixteen branches wrap the 4-bit retire counter back to zero
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = mk($sformatf("t6_br%0d_fetch", i), 0, OP_BEQ, 1, 0, 1, 0, e(3'd0, EN_FETCHAK, 2'd0, 4'(i)));
      applyStimulus(v);
      checkOutput(v);
      v = mk($sformatf("t6_br%0d_decode", i), 0, OP_BEQ, 1, 0, 1, 0, e(3'd1, EN_NONE, 2'd0, 4'(i)));
      applyStimulus(v);
      checkOutput(v);
      v = mk($sformatf("t6_br%0d_exec", i), 0, OP_BEQ, 1, 0, 1, 0, e(3'd2, EN_BRANCH, 2'd0, 4'(i)));
      applyStimulus(v);
      checkOutput(v);
    end
    applyStimulus(mk("t6_wrap", 0, OP_ADDI, 1, 0, 0, 0, e(3'd0, EN_FETCH, 2'd0, 4'd0)));
    checkVal("t6_wrap", observed(), e(3'd0, EN_FETCH, 2'd0, 4'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
